// File: rtl/esl_sysid_uptime.sv
// System-ID / uptime Avalon-MM slave: ID, build timestamp, prescaled uptime with atomic 64-bit readout.
// Optional heartbeat output is built when SYSID_HEARTBEAT_EN is defined.
module esl_sysid_uptime #(
    parameter logic [31:0] ID_VALUE  = 32'h0000_E51D,
    parameter logic [31:0] TIMESTAMP = 32'd1620591740,
    parameter int unsigned TICK_DIV  = 50,
    parameter int unsigned CNT_W     = 64,
    parameter int unsigned HB_TICKS  = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        heartbeat
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [15:0] CAPS_DIV  = 16'(TICK_DIV);
    localparam logic [7:0]  CAPS_W    = 8'(CNT_W);
`ifdef SYSID_HEARTBEAT_EN
    localparam logic        CAPS_HB   = 1'b1;
`else
    localparam logic        CAPS_HB   = 1'b0;
`endif

    generate
        if (TICK_DIV < 1 || TICK_DIV > 65535 || CNT_W < 33 || CNT_W > 64 || HB_TICKS < 1) begin : g_bad_params
            $error("esl_sysid_uptime: parameter out of range");
        end
    endgenerate

    logic [15:0]       presc;
    logic [CNT_W-1:0]  uptime;
    logic [31:0]       hi_shadow;
    logic [31:0]       scratch0;
    logic [31:0]       scratch1;
    logic              freeze;
    logic              wr_en;
    logic              ctrl_wr;
    logic              clear;
    logic              tick;
    logic [31:0]       rd_mux;

    // A read wins over a coincident write; CTRL bits live in byte lane 0.
    assign wr_en   = write & ~read;
    assign ctrl_wr = wr_en && (address == 3'd6) && byteenable[0];
    assign clear   = ctrl_wr & writedata[1];
    assign tick    = ~freeze && (presc == TICK_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc  <= '0;
            uptime <= '0;
        end else if (clear) begin
            presc  <= '0;
            uptime <= '0;
        end else if (!freeze) begin
            if (tick) begin
                presc  <= '0;
                uptime <= uptime + CNT_W'(1);
            end else begin
                presc  <= presc + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch0 <= '0;
            scratch1 <= '0;
            freeze   <= 1'b0;
        end else if (wr_en) begin
            case (address)
                3'd4: begin
                    for (int unsigned i = 0; i < 4; i++)
                        if (byteenable[i]) scratch0[8*i +: 8] <= writedata[8*i +: 8];
                end
                3'd5: begin
                    for (int unsigned i = 0; i < 4; i++)
                        if (byteenable[i]) scratch1[8*i +: 8] <= writedata[8*i +: 8];
                end
                3'd6: begin
                    if (byteenable[0]) freeze <= writedata[0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: rd_mux = ID_VALUE;
            3'd1: rd_mux = TIMESTAMP;
            3'd2: rd_mux = uptime[31:0];
            3'd3: rd_mux = hi_shadow;
            3'd4: rd_mux = scratch0;
            3'd5: rd_mux = scratch1;
            3'd6: rd_mux = {31'b0, freeze};
            3'd7: rd_mux = {CAPS_DIV, CAPS_W, 7'b0, CAPS_HB};
            default: rd_mux = '0;
        endcase
    end

    // Reading UPTIME_LO snapshots the upper half so a following HI read is never torn.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            hi_shadow     <= '0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
                if (address == 3'd2) hi_shadow <= 32'(uptime[CNT_W-1:32]);
            end
        end
    end

`ifdef SYSID_HEARTBEAT_EN
    localparam int unsigned     HB_W    = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_TICKS - 1);

    logic [HB_W-1:0] hb_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (clear) begin
            hb_cnt    <= '0;
        end else if (tick) begin
            if (hb_cnt == HB_LAST) begin
                hb_cnt    <= '0;
                heartbeat <= ~heartbeat;
            end else begin
                hb_cnt    <= hb_cnt + HB_W'(1);
            end
        end
    end
`else
    assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_esl_sysid_uptime.sv
// Randomised bench for esl_sysid_uptime against a cycle-count reference model, plus directed literal checks.
// Honours SYSID_HEARTBEAT_EN for the CAPS and heartbeat expectations.
module tb_esl_sysid_uptime;

    localparam int unsigned TD = 4;
    localparam int unsigned HB = 3;
    localparam int unsigned CW = 64;
`ifdef SYSID_HEARTBEAT_EN
    localparam logic [31:0] HB_BIT = 32'd1;
`else
    localparam logic [31:0] HB_BIT = 32'd0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rd_a, rd_b;
    logic        rv_a, rv_b, hb_a, hb_b;

    always #5 clock = ~clock;

    esl_sysid_uptime #(.TICK_DIV(TD), .CNT_W(CW), .HB_TICKS(HB)) u_dut (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_a), .readdatavalid(rv_a), .heartbeat(hb_a)
    );

    esl_sysid_uptime u_def (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_b), .readdatavalid(rv_b), .heartbeat(hb_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input logic [63:0] act, input logic [63:0] lo, input logic [63:0] hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: uptime is derived from the number of unfrozen cycles since the last clear.
    bit              model_on = 1'b1;
    longint unsigned m_n;
    bit              m_freeze;
    logic [31:0]     m_s0, m_s1, m_shadow, m_rdata;
    bit              m_valid;
    longint unsigned m_hb_base;

    function automatic longint unsigned m_uptime();
        return m_n / TD;
    endfunction

    function automatic logic m_hb();
`ifdef SYSID_HEARTBEAT_EN
        return logic'((m_hb_base + m_uptime() / HB) % 2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_word(input logic [2:0] a);
        longint unsigned up;
        up = m_uptime();
        case (a)
            3'd0: return 32'h0000_E51D;
            3'd1: return 32'd1620591740;
            3'd2: return up[31:0];
            3'd3: return m_shadow;
            3'd4: return m_s0;
            3'd5: return m_s1;
            3'd6: return {31'b0, m_freeze};
            default: return (TD << 16) | (CW << 8) | HB_BIT;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin
        longint unsigned up_before;
        bit clr;
        if (reset) begin
            m_n = 0; m_freeze = 0; m_s0 = 0; m_s1 = 0; m_shadow = 0;
            m_rdata = 0; m_valid = 0; m_hb_base = 0;
        end else begin
            up_before = m_uptime();
            m_valid = read;
            if (read) begin
                m_rdata = m_word(address);
                if (address == 3'd2) m_shadow = up_before[63:32];
            end
            clr = write && !read && address == 3'd6 && byteenable[0] && writedata[1];
            if (clr) begin
                m_hb_base += up_before / HB;
                m_n = 0;
            end else if (!m_freeze) begin
                m_n++;
            end
            if (write && !read) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i] && address == 3'd4) m_s0[8*i +: 8] = writedata[8*i +: 8];
                    if (byteenable[i] && address == 3'd5) m_s1[8*i +: 8] = writedata[8*i +: 8];
                end
                if (address == 3'd6 && byteenable[0]) m_freeze = writedata[0];
            end
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            check("model_rdv", {63'b0, rv_a}, {63'b0, m_valid});
            check("model_rdata", {32'b0, rd_a}, {32'b0, m_rdata});
            check("model_hb", {63'b0, hb_a}, {63'b0, m_hb()});
        end
    end

    task automatic bus_read(input logic [2:0] a, output logic [31:0] da);
        @(posedge clock); #1;
        read = 1'b1; write = 1'b0; address = a;
        @(negedge clock);
        check("rdv_pre", {63'b0, rv_a}, 64'd0);
        @(posedge clock); #1;
        read = 1'b0;
        @(negedge clock);
        check("rdv_lat", {63'b0, rv_a}, 64'd1);
        da = rd_a;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clock); #1;
        write = 1'b1; read = 1'b0; address = a; writedata = d; byteenable = be;
        @(posedge clock); #1;
        write = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v, v2;
        int r;
        bit found;
        reset = 1'b1; read = 0; write = 0; address = 0; writedata = 0; byteenable = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_rdata", {32'b0, rd_a}, 64'd0);
        check("reset_rdv", {63'b0, rv_a}, 64'd0);
        check("reset_hb", {62'b0, hb_a, hb_b}, 64'd0);
        @(posedge clock); #1 reset = 1'b0;

        bus_read(3'd0, v);
        check("id", {32'b0, rd_b}, 64'h0000_E51D);
        bus_read(3'd1, v);
        check("timestamp", {32'b0, rd_b}, 64'd1620591740);
        bus_read(3'd7, v);
        check("caps_def", {32'b0, rd_b}, {32'b0, 32'h0032_4000 | HB_BIT});
        check("caps_dut", {32'b0, v}, {32'b0, 32'h0004_4000 | HB_BIT});

        bus_write(3'd4, 32'hDEAD_BEEF, 4'b1111);
        bus_write(3'd4, 32'h1234_5678, 4'b0101);
        bus_read(3'd4, v);
        check("scratch_mask", {32'b0, v}, 64'hDE34_BE78);
        bus_write(3'd0, 32'h0, 4'b1111);
        bus_read(3'd0, v);
        check("id_ro", {32'b0, v}, 64'h0000_E51D);

        bus_write(3'd5, 32'hA5A5_0001, 4'b1111);
        @(posedge clock); #1;
        read = 1'b1; write = 1'b1; address = 3'd5; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
        @(negedge clock);
        check("rw_old", {32'b0, rd_a}, 64'hA5A5_0001);
        bus_read(3'd5, v);
        check("rw_kept", {32'b0, v}, 64'hA5A5_0001);

        bus_write(3'd6, 32'h2, 4'b0001);
        repeat (38) @(posedge clock);
        bus_read(3'd2, v);
        check_range("uptime_rate", {32'b0, v}, 64'd9, 64'd11);

        bus_write(3'd6, 32'h1, 4'b0001);
        bus_read(3'd2, v);
        repeat (100) @(posedge clock);
        bus_read(3'd2, v2);
        check("freeze_hold", {32'b0, v2}, {32'b0, v});
        bus_write(3'd6, 32'h0, 4'b0001);

        found = 1'b0;
        for (int k = 0; k < 2 * TD + 2; k++) begin
            @(posedge clock); #1;
            if (!m_freeze && (m_n % TD) == TD - 1) begin
                found = 1'b1;
                break;
            end
        end
        check("tick_phase_found", {63'b0, found}, 64'd1);
        write = 1'b1; address = 3'd6; writedata = 32'h2; byteenable = 4'b0001;
        @(posedge clock); #1;
        write = 1'b0; read = 1'b1; address = 3'd2;
        @(posedge clock); #1;
        read = 1'b0;
        @(negedge clock);
        check("clear_tick", {32'b0, rd_a}, 64'd0);

        for (int c = 0; c < 2500; c++) begin
            @(posedge clock); #1;
            r = $urandom_range(0, 99);
            read = 1'b0; write = 1'b0;
            address = 3'($urandom_range(0, 7));
            writedata = $urandom;
            byteenable = 4'($urandom_range(0, 15));
            if (r < 45) begin
                read = 1'b1;
            end else if (r < 55) begin
                read = 1'b1; write = 1'b1;
            end else if (r < 85) begin
                write = 1'b1;
                if (address == 3'd6) address = 3'd4;
            end else if (r < 90) begin
                write = 1'b1; address = 3'd6;
                writedata[0] = ($urandom_range(0, 3) == 0);
                writedata[1] = ($urandom_range(0, 7) == 0);
            end
        end
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;

        @(posedge clock); #1;
        read = 1'b1; address = 3'd4;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        read = 1'b0;
        @(negedge clock);
        check("abort_rdv", {62'b0, rv_a, rv_b}, 64'd0);
        check("abort_rdata", {rd_a, rd_b}, 64'd0);
        check("abort_hb", {63'b0, hb_a}, 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("abort_no_rdv", {62'b0, rv_a, rv_b}, 64'd0);

        model_on = 1'b0;
        @(posedge clock); #1;
        force u_dut.uptime = 64'h0000_0000_FFFF_FFFF;
        repeat (2 * TD) @(posedge clock);
        bus_read(3'd2, v);
        check("carry_lo", {32'b0, v}, 64'hFFFF_FFFF);
        release u_dut.uptime;
        bus_read(3'd3, v);
        check("carry_hi", {32'b0, v}, 64'd0);
        repeat (3 * TD) @(posedge clock);
        bus_read(3'd2, v);
        check_range("carry_lo_after", {32'b0, v}, 64'd0, 64'd63);
        bus_read(3'd3, v);
        check("carry_hi_after", {32'b0, v}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/esl_sysid_uptime.md
Name: esl_sysid_uptime

Overview:
Parametrised successor to the fixed system-ID slave. It is an Avalon-MM slave on the NIOS II data bus and exposes an 8-word register map:
- read-only ID and build timestamp,
- a prescaled free-running uptime counter with atomic 64-bit readout,
- two scratch registers,
- a control register,
- a capability word.
Software uses it to identify the FPGA image, detect bus faults and timestamp events.

Parameters:
ID_VALUE, 32'h0000_E51D, value returned at word 0
TIMESTAMP, 32'd1620591740, build timestamp returned at word 1
TICK_DIV, 50, clock cycles per uptime tick; legal range 1..65535 (50 gives 1 us at 50 MHz)
CNT_W, 64, uptime counter width; legal range 33..64
HB_TICKS, 500000, uptime ticks per heartbeat toggle (used only with SYSID_HEARTBEAT_EN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  3  word address
read  in  1  read strobe, one cycle per access
write  in  1  write strobe, one cycle per access
writedata  in  32  write data
byteenable  in  4  byte lanes for writes
readdata  out  32  registered read data
readdatavalid  out  1  high for one cycle, 1 cycle after read
heartbeat  out  1  status LED toggle output

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high: clock and reset ports named `clock` and `reset`.
- Reset values: readdata=0, readdatavalid=0, heartbeat=0, prescaler=0, uptime=0, hi-shadow=0, scratch0/1=0, ctrl=0.
- Reset asserted mid-access: any pending readdatavalid is dropped. No response follows the aborted read.
- Address map:
  - 0 ID: RO
  - 1 TIMESTAMP: RO
  - 2 UPTIME_LO: RO
  - 3 UPTIME_HI: RO
  - 4 SCRATCH0: RW
  - 5 SCRATCH1: RW
  - 6 CTRL: bit0 FREEZE is RW; bit1 CLEAR is write-1, self-clearing, reads 0; other bits read 0
  - 7 CAPS: RO; [31:16]=TICK_DIV[15:0], [15:8]=CNT_W, [0]=1 if heartbeat compiled in, other bits 0
- Read timing:
  - No waitrequest; fixed read latency 1.
  - A read in cycle N gives readdata and readdatavalid=1 in cycle N+1.
  - readdata holds its last value while readdatavalid=0.
- Write timing and masking:
  - A write takes effect at the clock edge of the cycle in which it is presented.
  - byteenable masks the bytes of SCRATCH0, SCRATCH1 and CTRL.
  - Writes to RO words are ignored.
- read and write asserted in the same cycle: the read is serviced and the write is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 and produces a one-cycle tick at the wrap.
  - TICK_DIV=1 gives a tick every cycle.
  - When FREEZE=1, both the prescaler and uptime hold their values.
- Uptime counter:
  - Increments on each tick and wraps from 2^CNT_W-1 to 0 silently.
- CLEAR:
  - Writing CTRL with bit1=1 zeroes the prescaler and uptime at that edge.
  - CLEAR takes priority over a coincident tick.
  - FREEZE takes the written bit0 value in the same write.
- Atomic readout:
  - A read of UPTIME_LO returns uptime[31:0] as sampled in the read cycle, before any increment at that edge.
  - At the same edge, uptime[CNT_W-1:32] is captured into the hi-shadow, zero-extended to 32 bits.
  - A read of UPTIME_HI returns the hi-shadow and does not sample the live counter.
  - A CLEAR does not modify the hi-shadow.

Optional Feature:
SYSID_HEARTBEAT_EN
- Defined:
  - A counter of width clog2(HB_TICKS) counts uptime ticks.
  - heartbeat toggles every HB_TICKS ticks.
  - The counter freezes with FREEZE and is zeroed by CLEAR and reset.
  - CAPS[0]=1.
- Undefined:
  - No heartbeat counter logic is built.
  - heartbeat is tied to 0.
  - CAPS[0]=0.

Test Plan:
- After reset, read words 0, 1 and 7 (TICK_DIV=50, CNT_W=64):
  - readdatavalid goes high exactly 1 cycle after each read;
  - data is 32'h0000_E51D, 32'd1620591740 and 32'h0032_4001 with the heartbeat macro defined, 32'h0032_4000 without.
- Byte-masked scratch write:
  - write SCRATCH0=32'hDEAD_BEEF with byteenable=4'b1111, then 32'h1234_5678 with byteenable=4'b0101;
  - readback is 32'hDE34_BE78;
  - a write to word 0 leaves ID unchanged.
- Uptime rate (TICK_DIV=4): clear, then read UPTIME_LO 40 cycles later -> 10, ±1 depending on access phase.
- Atomic carry (TICK_DIV=1):
  - preload uptime near 0x0000_0000_FFFF_FFFF via force, or run with CNT_W=33 to reach it;
  - read LO in the cycle that sees 0xFFFF_FFFF, then read HI;
  - the pair equals the pre-carry value {0, FFFF_FFFF}, not a torn value.
- Control:
  - write FREEZE=1 -> uptime is constant over 100 cycles;
  - write CTRL=2'b10 coincident with a tick -> next read gives 0.
- Simultaneous read+write to SCRATCH1 -> old value returned, SCRATCH1 unchanged.
- Reset asserted between read and readdatavalid -> no readdatavalid, all outputs 0.
